// File: rtl/cpu_clock_ctrl.sv
// Run/halt/step clock-enable controller with programmable divider for the softcore.
// Define CPU_CLOCK_CTRL_TICK_COUNT_EN to add the o_tick_count issued-tick counter.
module cpu_clock_ctrl #(
    parameter int COUNT_WIDTH = 24,
    parameter int DEFAULT_DIV = 6_000_000,
    parameter int STEP_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [1:0]             i_cmd_op,
    input  logic [COUNT_WIDTH-1:0] i_cmd_arg,
    output logic                   o_tick,
    output logic                   o_running,
    output logic [STEP_WIDTH-1:0]  o_steps_left,
    output logic                   o_done
`ifdef CPU_CLOCK_CTRL_TICK_COUNT_EN
    ,
    output logic [31:0]            o_tick_count
`endif
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT    = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_STEP    = 2'd2;
    localparam logic [1:0] OP_SET_DIV = 2'd3;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] div_q, div_d;
    logic [COUNT_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                   pend_q, pend_d;
    logic [STEP_WIDTH-1:0]  steps_q, steps_d;
    logic                   tick_q, tick_d;
    logic                   done_q, done_d;
    logic                   run_q;

    logic                   accept;
    logic                   active;
    logic                   wrap;
    logic [STEP_WIDTH-1:0]  step_arg;

    assign accept   = i_cmd_valid && !pend_q;
    assign active   = (state_q != ST_HALT);
    assign wrap     = active && (count_q == div_q);
    assign step_arg = i_cmd_arg[STEP_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        steps_d    = steps_q;
        tick_d     = wrap;
        done_d     = 1'b0;
        count_d    = '0;

        // Wrap-edge bookkeeping first; a command on the same edge overrides it.
        if (wrap) begin
            if (pend_q) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
            end
            if (state_q == ST_STEP) begin
                steps_d = steps_q - STEP_WIDTH'(1);
                if (steps_q == STEP_WIDTH'(1)) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end
            end
        end

        if (accept) begin
            unique case (i_cmd_op)
                OP_HALT: begin
                    state_d = ST_HALT;
                    steps_d = '0;
                end
                OP_RUN: begin
                    state_d = ST_RUN;
                    steps_d = '0;
                    done_d  = 1'b0;
                end
                OP_STEP: begin
                    if (step_arg != '0) begin
                        state_d = ST_STEP;
                        steps_d = step_arg;
                        done_d  = 1'b0;
                    end
                end
                OP_SET_DIV: begin
                    if (active) begin
                        pend_d     = 1'b1;
                        pend_div_d = i_cmd_arg;
                    end else begin
                        div_d = i_cmd_arg;
                    end
                end
                default: ;
            endcase
        end

        // No wrap will ever come while halted, so never leave a divisor parked.
        if (state_d == ST_HALT && pend_d) begin
            div_d  = pend_div_d;
            pend_d = 1'b0;
        end

        if (state_d == ST_HALT || !active || wrap)
            count_d = '0;
        else
            count_d = count_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_HALT;
            count_q    <= '0;
            div_q      <= COUNT_WIDTH'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            steps_q    <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            steps_q    <= steps_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            run_q      <= (state_d != ST_HALT);
        end
    end

    assign o_tick       = tick_q;
    assign o_done       = done_q;
    assign o_running    = run_q;
    assign o_steps_left = steps_q;
    assign o_cmd_ready  = !pend_q;

`ifdef CPU_CLOCK_CTRL_TICK_COUNT_EN
    logic [31:0] tick_count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            tick_count_q <= '0;
        else if (tick_d)
            tick_count_q <= tick_count_q + 32'd1;
    end

    assign o_tick_count = tick_count_q;
`endif

endmodule
